// File: rtl/arm_mem_pkg.sv
// Shared types for the data-memory responder slice: FSM states, word type and bytes per word.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data RAM: asynchronous read, synchronous write with one write enable per byte.
module dmem_array
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                  clk_i,
    input  logic [WORD_BYTES-1:0] we_i,
    input  logic [AW-1:0]         addr_i,
    input  word_t                 wdata_i,
    output word_t                 rdata_o
);

    word_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, WAIT_CYCLES wait states, registered response out.
// Optional per-byte store enables (req_be port) when DMEM_BYTE_EN is defined.
module dmem_responder
    import arm_mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state | meaning
    // IDLE  | req_ready=1, waiting for a request
    // WAIT  | counting down wait states; access happens on the last one
    // RESP  | rsp_valid=1, response held until rsp_ready

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);
    localparam logic [29:0] BASE_WORD = ADDR_BASE[31:2];
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    dmem_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    word_t       wdata_q;
    word_t       rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        latch_en;

    logic [29:0]           word_idx;
    logic                  acc_err;
    logic [WORD_BYTES-1:0] be_mask;
    logic [WORD_BYTES-1:0] ram_we;
    word_t                 ram_rdata;

`ifdef DMEM_BYTE_EN
    logic [3:0] be_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            be_q <= 4'h0;
        end else if (latch_en) begin
            be_q <= req_be;
        end
    end

    assign be_mask = be_q;
`else
    assign be_mask = {WORD_BYTES{1'b1}};
`endif

    // Addresses below ADDR_BASE wrap to a huge index and fail the range check.
    assign word_idx = addr_q[31:2] - BASE_WORD;
    assign acc_err  = (addr_q[1:0] != 2'b00) || ({2'b00, word_idx} >= DEPTH_W);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (word_idx[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= '0;
        end else if (latch_en) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // WAIT always runs until the counter is zero, so a zero wait count still
    // spends one cycle there and latency is WAIT_CYCLES+1 edges in every build.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        latch_en  = 1'b0;
        ram_we    = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    latch_en = 1'b1;
                    cnt_d    = WAIT_INIT;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (!we_q && !acc_err) ? ram_rdata : '0;
                    if (we_q && !acc_err) begin
                        ram_we = be_mask;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: two instances (2 wait states / base 0, 0 wait states / base 0x100)
// checked against a word-array reference model with per-byte "known" tracking.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          total;
    int          bad;

    int          W_P     [2] = '{2, 0};
    int          DEPTH_P [2] = '{64, 16};
    logic [31:0] BASE_P  [2] = '{32'h0, 32'h100};

    logic [31:0] mmem [2][64];
    logic [3:0]  kn   [2][64];

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .ADDR_BASE(32'h0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
`ifdef DMEM_BYTE_EN
        .req_be    (req_be[0]),
`endif
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_BASE(32'h100)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
`ifdef DMEM_BYTE_EN
        .req_be    (req_be[1]),
`endif
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input int d);
        chk("rst_req_ready", req_ready[d], 1);
        chk("rst_rsp_valid", rsp_valid[d], 0);
        chk("rst_rsp_rdata", rsp_rdata[d], 0);
        chk("rst_rsp_err",   rsp_err[d],   0);
    endtask

    // One full transaction on instance d, checked against the reference model.
    task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input bit keep);
        int          cyc;
        bit          err;
        logic [31:0] off;
        int          idx;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic [31:0] got_rd;
        logic        got_err;
        logic [3:0]  eff_be;

        cyc = 0;
        while (req_ready[d] !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("idle_ready", req_ready[d], 1);

        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        req_be[d]    = be;
        @(posedge clk); #1;
        if (!keep) req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);

        off = (addr - BASE_P[d]) >> 2;
        err = (addr % 4 != 0) || (off >= 32'(DEPTH_P[d]));
        idx = err ? 0 : int'(off);
`ifdef DMEM_BYTE_EN
        eff_be = be;
`else
        eff_be = 4'hF;
`endif
        exp_rd = 32'h0;
        mask   = 32'hFFFF_FFFF;
        if (!err && !we) begin
            exp_rd = mmem[d][idx];
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = kn[d][idx][b] ? 8'hFF : 8'h00;
        end
        if (!err && we) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) begin
                    mmem[d][idx][8*b +: 8] = wd[8*b +: 8];
                    kn[d][idx][b] = 1'b1;
                end
            end
        end

        cyc = 0;
        while (rsp_valid[d] !== 1'b1 && cyc < 300) begin
            rsp_ready[d] = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        rsp_ready[d] = 1'b0;
        chk("latency",    cyc, W_P[d] + 1);
        chk("busy_ready", req_ready[d], 0);
        chk("rsp_err",    rsp_err[d], err);
        chk("rsp_rdata",  rsp_rdata[d] & mask, exp_rd & mask);
        got_rd  = rsp_rdata[d];
        got_err = rsp_err[d];

        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid[d], 1);
            chk("hold_rdata", rsp_rdata[d], got_rd);
            chk("hold_err",   rsp_err[d], got_err);
            chk("hold_ready", req_ready[d], 0);
        end

        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        chk("post_valid", rsp_valid[d], 0);
        chk("post_rdata", rsp_rdata[d], 0);
        chk("post_ready", req_ready[d], 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_be[d]    = 4'hF;
            rsp_ready[d] = 1'b0;
            for (int i = 0; i < 64; i++) begin
                mmem[d][i] = 32'h0;
                kn[d][i]   = 4'h0;
            end
        end
        reset = 1'b1;
        #23;
        chk_idle_outputs(0);
        chk_idle_outputs(1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs(0);
        chk_idle_outputs(1);

        // Store then load at 0x64.
        txn(0, 1'b1, 32'h64, 32'h7, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h64, 32'h0, 4'hF, 0, 1'b0);
        chk("load_0x64_lit", mmem[0][25], 32'h7);

        // Errors leave word 0 alone.
        txn(0, 1'b1, 32'h0,   32'h1234_5678, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h65,  32'h0,         4'hF, 0, 1'b0);
        txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h0,   32'h0,         4'hF, 0, 1'b0);

        // Response backpressure.
        txn(0, 1'b0, 32'h64, 32'h0, 4'hF, 3, 1'b0);

        // Reset during WAIT aborts the store.
        txn(0, 1'b1, 32'h60, 32'h1111_2222, 4'hF, 0, 1'b0);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h60;
        req_wdata[0] = 32'hDEAD_BEEF;
        req_be[0]    = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_wait_ready", req_ready[0], 0);
        reset = 1'b1;
        #1;
        chk_idle_outputs(0);
        @(posedge clk); #1;
        reset = 1'b0;
        txn(0, 1'b0, 32'h60, 32'h0, 4'hF, 0, 1'b0);

        // Zero wait states, req_valid held high across transactions.
        txn(1, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hF, 0, 1'b1);
        txn(1, 1'b0, 32'h104, 32'h0,         4'hF, 1, 1'b1);
        txn(1, 1'b0, 32'hFC,  32'h0,         4'hF, 0, 1'b1);
        req_valid[1] = 1'b0;

`ifdef DMEM_BYTE_EN
        txn(0, 1'b1, 32'h40, 32'h0,         4'hF, 0, 1'b0);
        txn(0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'h4, 0, 1'b0);
        txn(0, 1'b0, 32'h40, 32'h0,         4'h0, 0, 1'b0);
        chk("be_0100_lit", mmem[0][16], 32'h00BB_0000);
        txn(0, 1'b1, 32'h40, 32'h1234_5678, 4'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h40, 32'h0,         4'hF, 0, 1'b0);
`endif

        for (int n = 0; n < 200; n++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            if (d == 0) a = 32'($urandom_range(0, 70)) * 4;
            else        a = 32'h100 + (32'($urandom_range(0, 20)) * 4) - 32'($urandom_range(0, 1)) * 8;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            txn(d, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
